// File: rtl/oram_dram_channel_striper_pkg.sv
// Shared constants and helpers for the DRAM channel striper.
// DDR3 command encodings follow the MIG native interface.
package oram_dram_channel_striper_pkg;

    localparam int unsigned DDR3CMD_WIDTH = 3;

    localparam logic [DDR3CMD_WIDTH-1:0] DDR3CMD_WRITE = 3'b000;
    localparam logic [DDR3CMD_WIDTH-1:0] DDR3CMD_READ  = 3'b001;

    // Ceiling log2, used for elaboration-time widths only.
    function automatic int unsigned log2_ceil(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(n)) r = 32'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/oram_dram_channel_striper_fifo.sv
// Small synchronous FIFO holding channel indices (read sequence / write route).
// Push is ignored when full and pop when empty; head is the registered slot at the read pointer.
module oram_chan_fifo
    import oram_dram_channel_striper_pkg::*;
#(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 16,
    localparam int unsigned AddrW = log2_ceil(Depth),
    localparam int unsigned CntW  = AddrW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [Width-1:0] i_din,
    input  logic             i_pop,
    output logic [Width-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CntW-1:0]  o_count
);

    logic [Width-1:0] r_mem [Depth];
    logic [AddrW-1:0] r_wr_ptr;
    logic [AddrW-1:0] r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AddrW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AddrW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CntW'(Depth));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/oram_dram_channel_striper.sv
// Steers backend DRAM commands and write beats to address-selected channels and
// returns read beats in issue order by only ever accepting from the oldest read's channel.
module oram_dram_channel_striper
    import oram_dram_channel_striper_pkg::*;
#(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned ChanLSB     = 0,
    parameter int unsigned DDRAWidth   = 28,
    parameter int unsigned DDRCWidth   = 3,
    parameter int unsigned DDRDWidth   = 512,
    parameter int unsigned SeqDepth    = 16,
    localparam int unsigned ChW        = log2_ceil(NumChannels),
    localparam int unsigned CntW       = log2_ceil(SeqDepth) + 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [DDRAWidth-1:0]             i_command_address,
    input  logic [DDRCWidth-1:0]             i_command,
    input  logic                             i_command_valid,
    output logic                             o_command_ready,
    input  logic [DDRDWidth-1:0]             i_write_data,
    input  logic                             i_write_data_valid,
    output logic                             o_write_data_ready,
    output logic [DDRDWidth-1:0]             o_read_data,
    output logic                             o_read_data_valid,
    input  logic                             i_read_data_ready,
    output logic [NumChannels*DDRAWidth-1:0] o_ch_command_address,
    output logic [NumChannels*DDRCWidth-1:0] o_ch_command,
    output logic [NumChannels-1:0]           o_ch_command_valid,
    input  logic [NumChannels-1:0]           i_ch_command_ready,
    input  logic [NumChannels*DDRDWidth-1:0] i_ch_read_data,
    input  logic [NumChannels-1:0]           i_ch_read_data_valid,
    output logic [NumChannels-1:0]           o_ch_read_data_ready,
    output logic [NumChannels*DDRDWidth-1:0] o_ch_write_data,
    output logic [NumChannels-1:0]           o_ch_write_data_valid,
    input  logic [NumChannels-1:0]           i_ch_write_data_ready,
    output logic [CntW-1:0]                  o_outstanding_reads
);

    logic [ChW-1:0]       w_ch;
    logic                 w_is_read;
    logic                 w_is_write;
    logic                 w_slot_ok;
    logic                 w_cmd_fire;
    logic                 w_rd_fire;
    logic                 w_wr_fire;
    logic [ChW-1:0]       w_rseq_head;
    logic                 w_rseq_full;
    logic                 w_rseq_empty;
    logic [CntW-1:0]      w_rseq_count;
    logic [ChW-1:0]       w_wroute_head;
    logic                 w_wroute_full;
    logic                 w_wroute_empty;
    logic [CntW-1:0]      w_wroute_count;
    logic                 w_unused_wroute_count;
    logic [DDRDWidth-1:0] w_ch_rdata [NumChannels];

    assign w_ch       = i_command_address[ChanLSB +: ChW];
    assign w_is_read  = (i_command == DDRCWidth'(DDR3CMD_READ));
    assign w_is_write = (i_command == DDRCWidth'(DDR3CMD_WRITE));

    // Full tracking uses pre-pop occupancy so ready never depends on the return path.
    always_comb begin
        w_slot_ok = 1'b1;
        if (w_is_read)       w_slot_ok = ~w_rseq_full;
        else if (w_is_write) w_slot_ok = ~w_wroute_full;
    end

    assign o_command_ready    = ~i_rst & i_ch_command_ready[w_ch] & w_slot_ok;
    assign w_cmd_fire         = i_command_valid & o_command_ready;

    assign o_write_data_ready = ~w_wroute_empty & i_ch_write_data_ready[w_wroute_head];
    assign w_wr_fire          = i_write_data_valid & o_write_data_ready;

    assign o_read_data_valid  = ~w_rseq_empty & i_ch_read_data_valid[w_rseq_head];
    assign o_read_data        = w_ch_rdata[w_rseq_head];
    assign w_rd_fire          = o_read_data_valid & i_read_data_ready;

    assign o_outstanding_reads   = w_rseq_count;
    assign w_unused_wroute_count = ^w_wroute_count;

    for (genvar g = 0; g < NumChannels; g++) begin : g_chan
        localparam logic [ChW-1:0] Idx = ChW'(g);
        assign o_ch_command_address[g*DDRAWidth +: DDRAWidth] = i_command_address;
        assign o_ch_command[g*DDRCWidth +: DDRCWidth]         = i_command;
        assign o_ch_command_valid[g]    = ~i_rst & i_command_valid & w_slot_ok & (w_ch == Idx);
        assign o_ch_write_data[g*DDRDWidth +: DDRDWidth]      = i_write_data;
        assign o_ch_write_data_valid[g] = i_write_data_valid & ~w_wroute_empty & (w_wroute_head == Idx);
        assign o_ch_read_data_ready[g]  = i_read_data_ready & ~w_rseq_empty & (w_rseq_head == Idx);
        assign w_ch_rdata[g]            = i_ch_read_data[g*DDRDWidth +: DDRDWidth];
    end

    oram_chan_fifo #(
        .Width (ChW),
        .Depth (SeqDepth)
    ) u_rseq (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_cmd_fire & w_is_read),
        .i_din   (w_ch),
        .i_pop   (w_rd_fire),
        .o_dout  (w_rseq_head),
        .o_full  (w_rseq_full),
        .o_empty (w_rseq_empty),
        .o_count (w_rseq_count)
    );

    oram_chan_fifo #(
        .Width (ChW),
        .Depth (SeqDepth)
    ) u_wroute (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_cmd_fire & w_is_write),
        .i_din   (w_ch),
        .i_pop   (w_wr_fire),
        .o_dout  (w_wroute_head),
        .o_full  (w_wroute_full),
        .o_empty (w_wroute_empty),
        .o_count (w_wroute_count)
    );

endmodule

// File: tb/tb_oram_dram_channel_striper.sv
// Bench for the channel striper: queue-based reference model with emulated channel controllers.
module tb_oram_dram_channel_striper;
    import oram_dram_channel_striper_pkg::*;

    localparam int unsigned NCH  = 2;
    localparam int unsigned AW   = 28;
    localparam int unsigned CW   = 3;
    localparam int unsigned DW   = 64;
    localparam int unsigned SD   = 4;
    localparam int unsigned CNTW = 3;
    localparam logic [CW-1:0] CMD_OTHER = 3'b100;

    logic              i_clk;
    logic              i_rst;
    logic [AW-1:0]     i_command_address;
    logic [CW-1:0]     i_command;
    logic              i_command_valid;
    logic              o_command_ready;
    logic [DW-1:0]     i_write_data;
    logic              i_write_data_valid;
    logic              o_write_data_ready;
    logic [DW-1:0]     o_read_data;
    logic              o_read_data_valid;
    logic              i_read_data_ready;
    logic [NCH*AW-1:0] o_ch_command_address;
    logic [NCH*CW-1:0] o_ch_command;
    logic [NCH-1:0]    o_ch_command_valid;
    logic [NCH-1:0]    i_ch_command_ready;
    logic [NCH*DW-1:0] i_ch_read_data;
    logic [NCH-1:0]    i_ch_read_data_valid;
    logic [NCH-1:0]    o_ch_read_data_ready;
    logic [NCH*DW-1:0] o_ch_write_data;
    logic [NCH-1:0]    o_ch_write_data_valid;
    logic [NCH-1:0]    i_ch_write_data_ready;
    logic [CNTW-1:0]   o_outstanding_reads;

    oram_dram_channel_striper #(
        .NumChannels (NCH),
        .ChanLSB     (0),
        .DDRAWidth   (AW),
        .DDRCWidth   (CW),
        .DDRDWidth   (DW),
        .SeqDepth    (SD)
    ) dut (
        .i_clk                 (i_clk),
        .i_rst                 (i_rst),
        .i_command_address     (i_command_address),
        .i_command             (i_command),
        .i_command_valid       (i_command_valid),
        .o_command_ready       (o_command_ready),
        .i_write_data          (i_write_data),
        .i_write_data_valid    (i_write_data_valid),
        .o_write_data_ready    (o_write_data_ready),
        .o_read_data           (o_read_data),
        .o_read_data_valid     (o_read_data_valid),
        .i_read_data_ready     (i_read_data_ready),
        .o_ch_command_address  (o_ch_command_address),
        .o_ch_command          (o_ch_command),
        .o_ch_command_valid    (o_ch_command_valid),
        .i_ch_command_ready    (i_ch_command_ready),
        .i_ch_read_data        (i_ch_read_data),
        .i_ch_read_data_valid  (i_ch_read_data_valid),
        .o_ch_read_data_ready  (o_ch_read_data_ready),
        .o_ch_write_data       (o_ch_write_data),
        .o_ch_write_data_valid (o_ch_write_data_valid),
        .i_ch_write_data_ready (i_ch_write_data_ready),
        .o_outstanding_reads   (o_outstanding_reads)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Data a channel returns for an address: ch0 addresses give 0xA?, ch1 addresses 0xB?.
    function automatic logic [DW-1:0] beat_of(input logic [AW-1:0] a);
        return (DW'(a[AW-1:4]) << 8) | DW'(a[0] ? 8'hB0 : 8'hA0) | DW'(a[3:0]);
    endfunction

    // Reference model state (written only by the monitor).
    int            rseq_m[$];
    int            wroute_m[$];
    logic [DW-1:0] chq0[$];
    logic [DW-1:0] chq1[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] rd_log[$];
    logic [NCH-1:0] ch_en;

    // Emulated channel controllers: present their oldest pending beat when enabled.
    always @(posedge i_clk) begin
        #2;
        i_ch_read_data_valid[0] = ch_en[0] && (chq0.size() > 0);
        i_ch_read_data_valid[1] = ch_en[1] && (chq1.size() > 0);
        i_ch_read_data[0 +: DW]  = (chq0.size() > 0) ? chq0[0] : '0;
        i_ch_read_data[DW +: DW] = (chq1.size() > 0) ? chq1[0] : '0;
    end

    int             m_ch, m_wh, m_rh;
    bit             m_is_rd, m_is_wr, m_slot, m_cr, m_wne, m_rne, m_wdr, m_rdv;
    logic [NCH-1:0] m_cv, m_wdv, m_rdr;
    logic [DW-1:0]  m_beat;

    // Compare every cycle against the model, then advance the model over the coming edge.
    always @(negedge i_clk) begin
        if (i_rst) begin
            rseq_m.delete(); wroute_m.delete();
            chq0.delete(); chq1.delete(); exp_rd.delete();
        end else begin
            m_ch    = int'(i_command_address[0]);
            m_is_rd = (i_command == DDR3CMD_READ);
            m_is_wr = (i_command == DDR3CMD_WRITE);
            m_slot  = m_is_rd ? (rseq_m.size() < SD) : m_is_wr ? (wroute_m.size() < SD) : 1'b1;
            m_cr    = i_ch_command_ready[m_ch] && m_slot;
            m_cv    = '0;
            if (i_command_valid && m_slot) m_cv[m_ch] = 1'b1;
            m_wne = wroute_m.size() > 0;
            m_wh  = m_wne ? wroute_m[0] : 0;
            m_wdr = m_wne && i_ch_write_data_ready[m_wh];
            m_wdv = '0;
            if (i_write_data_valid && m_wne) m_wdv[m_wh] = 1'b1;
            m_rne = rseq_m.size() > 0;
            m_rh  = m_rne ? rseq_m[0] : 0;
            m_rdv = m_rne && i_ch_read_data_valid[m_rh];
            m_rdr = '0;
            if (i_read_data_ready && m_rne) m_rdr[m_rh] = 1'b1;

            chk("cmd_valid", 256'(o_ch_command_valid), 256'(m_cv));
            chk("cmd_ready", 256'(o_command_ready), 256'(m_cr));
            chk("ch_cmd_addr", 256'(o_ch_command_address), 256'({i_command_address, i_command_address}));
            chk("ch_cmd", 256'(o_ch_command), 256'({i_command, i_command}));
            chk("ch_wdata", 256'(o_ch_write_data), 256'({i_write_data, i_write_data}));
            chk("ch_wdata_valid", 256'(o_ch_write_data_valid), 256'(m_wdv));
            chk("wdata_ready", 256'(o_write_data_ready), 256'(m_wdr));
            chk("rdata_valid", 256'(o_read_data_valid), 256'(m_rdv));
            chk("ch_rdata_ready", 256'(o_ch_read_data_ready), 256'(m_rdr));
            chk("outstanding", 256'(o_outstanding_reads), 256'(rseq_m.size()));

            if (m_rdv && i_read_data_ready) begin
                chk("rd_expected", 256'(exp_rd.size() > 0), 256'(1));
                if (exp_rd.size() > 0) chk("rd_data", 256'(o_read_data), 256'(exp_rd.pop_front()));
                rd_log.push_back(o_read_data);
                rseq_m.pop_front();
                if (m_rh == 0) void'(chq0.pop_front());
                else           void'(chq1.pop_front());
            end
            if (i_write_data_valid && m_wdr) wroute_m.pop_front();
            if (i_command_valid && m_cr) begin
                if (m_is_rd) begin
                    rseq_m.push_back(m_ch);
                    exp_rd.push_back(beat_of(i_command_address));
                    m_beat = beat_of(o_ch_command_address[m_ch*AW +: AW]);
                    if (m_ch == 0) chq0.push_back(m_beat);
                    else           chq1.push_back(m_beat);
                end
                if (m_is_wr) wroute_m.push_back(m_ch);
            end
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_command_valid    = 1'b0;
        i_command_address  = '0;
        i_command          = CMD_OTHER;
        i_write_data_valid = 1'b0;
        i_write_data       = '0;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [CW-1:0] c);
        bit done;
        done = 1'b0;
        i_command_valid   = 1'b1;
        i_command_address = a;
        i_command         = c;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge i_clk);
            done = o_command_ready;
            cyc();
        end
        i_command_valid = 1'b0;
        chk("issue_accepted", 256'(done), 256'(1));
    endtask

    task automatic wait_log(input int n);
        for (int k = 0; k < 60 && rd_log.size() < n; k++) cyc();
        chk("log_len", 256'(rd_log.size()), 256'(n));
    endtask

    task automatic chk_log(input string name, input int idx, input logic [DW-1:0] v);
        if (idx < rd_log.size()) chk(name, 256'(rd_log[idx]), 256'(v));
        else                     chk(name, 256'(rd_log.size()), 256'(idx + 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit acc, wacc;
        int r;

        i_rst = 1'b1;
        idle_inputs();
        i_read_data_ready     = 1'b0;
        ch_en                 = '0;
        i_ch_command_ready    = 2'b11;
        i_ch_write_data_ready = 2'b11;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_outstanding", 256'(o_outstanding_reads), 256'(0));
        chk("rst_rdata_valid", 256'(o_read_data_valid), 256'(0));
        chk("rst_cmd_ready", 256'(o_command_ready), 256'(0));
        i_rst = 1'b0;
        cyc();

        // Reorder: ch1 offers its beats first, but they must follow ch0's in issue order.
        base = rd_log.size();
        i_read_data_ready = 1'b1;
        issue(28'd0, DDR3CMD_READ);
        issue(28'd1, DDR3CMD_READ);
        issue(28'd2, DDR3CMD_READ);
        issue(28'd3, DDR3CMD_READ);
        chk("t1_outstanding", 256'(o_outstanding_reads), 256'(4));
        ch_en = 2'b10;
        repeat (3) begin
            @(negedge i_clk);
            chk("t1_hol_block", 256'(o_read_data_valid), 256'(0));
            chk("t1_ready_on_head", 256'(o_ch_read_data_ready), 256'(2'b01));
            cyc();
        end
        ch_en = 2'b11;
        wait_log(base + 4);
        chk_log("t1_beat0", base + 0, 64'hA0);
        chk_log("t1_beat1", base + 1, 64'hB1);
        chk_log("t1_beat2", base + 2, 64'hA2);
        chk_log("t1_beat3", base + 3, 64'hB3);
        chk("t1_drained", 256'(o_outstanding_reads), 256'(0));
        ch_en = 2'b00;

        // Sequence FIFO full: fifth read waits, and a same-cycle pop does not free the slot.
        base = rd_log.size();
        issue(28'd4, DDR3CMD_READ);
        issue(28'd5, DDR3CMD_READ);
        issue(28'd6, DDR3CMD_READ);
        issue(28'd7, DDR3CMD_READ);
        i_command_valid   = 1'b1;
        i_command_address = 28'd8;
        i_command         = DDR3CMD_READ;
        @(negedge i_clk);
        chk("t2_full_ready", 256'(o_command_ready), 256'(0));
        chk("t2_full_count", 256'(o_outstanding_reads), 256'(4));
        cyc();
        ch_en = 2'b01;
        @(negedge i_clk);
        chk("t2_pop_valid", 256'(o_read_data_valid), 256'(1));
        chk("t2_full_during_pop", 256'(o_command_ready), 256'(0));
        cyc();
        ch_en = 2'b00;
        @(negedge i_clk);
        chk("t2_ready_after_pop", 256'(o_command_ready), 256'(1));
        chk("t2_count_after_pop", 256'(o_outstanding_reads), 256'(3));
        cyc();
        i_command_valid = 1'b0;
        ch_en = 2'b11;
        wait_log(base + 5);
        chk_log("t2_beat0", base + 0, 64'hA4);
        chk_log("t2_beat1", base + 1, 64'hB5);
        chk_log("t2_beat2", base + 2, 64'hA6);
        chk_log("t2_beat3", base + 3, 64'hB7);
        chk_log("t2_beat4", base + 4, 64'hA8);
        ch_en = 2'b00;

        // Write beat before its command is held off, then routed to ch1.
        i_write_data_valid = 1'b1;
        i_write_data       = 64'hDEAD;
        @(negedge i_clk);
        chk("t3_beat_held", 256'(o_write_data_ready), 256'(0));
        chk("t3_no_wvalid", 256'(o_ch_write_data_valid), 256'(0));
        cyc();
        i_command_valid   = 1'b1;
        i_command_address = 28'd1;
        i_command         = DDR3CMD_WRITE;
        @(negedge i_clk);
        chk("t3_wcmd_ready", 256'(o_command_ready), 256'(1));
        chk("t3_wcmd_valid", 256'(o_ch_command_valid), 256'(2'b10));
        chk("t3_beat_still_held", 256'(o_write_data_ready), 256'(0));
        cyc();
        i_command_valid = 1'b0;
        @(negedge i_clk);
        chk("t3_wdr", 256'(o_write_data_ready), 256'(1));
        chk("t3_wvalid", 256'(o_ch_write_data_valid), 256'(2'b10));
        chk("t3_wdata", 256'(o_ch_write_data[DW +: DW]), 256'(64'hDEAD));
        cyc();
        i_write_data_valid = 1'b0;
        @(negedge i_clk);
        chk("t3_route_empty", 256'(o_write_data_ready), 256'(0));
        cyc();

        // Stalled ch0 blocks the read behind it; both then issue in order.
        base = rd_log.size();
        i_ch_command_ready = 2'b10;
        i_command_valid    = 1'b1;
        i_command_address  = 28'd0;
        i_command          = DDR3CMD_READ;
        repeat (3) begin
            @(negedge i_clk);
            chk("t4_stall_ready", 256'(o_command_ready), 256'(0));
            chk("t4_stall_valid", 256'(o_ch_command_valid), 256'(2'b01));
            chk("t4_stall_count", 256'(o_outstanding_reads), 256'(0));
            cyc();
        end
        i_ch_command_ready = 2'b11;
        issue(28'd0, DDR3CMD_READ);
        issue(28'd1, DDR3CMD_READ);
        ch_en = 2'b11;
        wait_log(base + 2);
        chk_log("t4_beat0", base + 0, 64'hA0);
        chk_log("t4_beat1", base + 1, 64'hB1);
        ch_en = 2'b00;

        // Asynchronous reset with three reads outstanding and channel beats pending.
        issue(28'd0, DDR3CMD_READ);
        issue(28'd1, DDR3CMD_READ);
        issue(28'd2, DDR3CMD_READ);
        chk("t5_pre_count", 256'(o_outstanding_reads), 256'(3));
        i_rst              = 1'b1;
        i_command_valid    = 1'b1;
        i_command_address  = 28'd3;
        i_command          = DDR3CMD_READ;
        i_write_data_valid = 1'b1;
        ch_en              = 2'b11;
        #2;
        chk("t5_count", 256'(o_outstanding_reads), 256'(0));
        chk("t5_cmd_valid", 256'(o_ch_command_valid), 256'(0));
        chk("t5_cmd_ready", 256'(o_command_ready), 256'(0));
        chk("t5_rdata_valid", 256'(o_read_data_valid), 256'(0));
        chk("t5_ch_rdata_ready", 256'(o_ch_read_data_ready), 256'(0));
        chk("t5_wvalid", 256'(o_ch_write_data_valid), 256'(0));
        chk("t5_wdr", 256'(o_write_data_ready), 256'(0));
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        idle_inputs();
        ch_en = 2'b00;
        i_rst = 1'b0;
        cyc();
        base = rd_log.size();
        issue(28'd2, DDR3CMD_READ);
        chk("t5_post_count", 256'(o_outstanding_reads), 256'(1));
        ch_en = 2'b11;
        wait_log(base + 1);
        chk_log("t5_roundtrip", base, 64'hA2);

        // Randomized traffic; the monitor checks every cycle and every returned beat.
        acc  = 1'b0;
        wacc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!i_command_valid || acc) begin
                if ($urandom_range(0, 9) < 6) begin
                    i_command_valid   = 1'b1;
                    i_command_address = AW'($urandom);
                    r = int'($urandom_range(0, 9));
                    i_command = (r < 5) ? DDR3CMD_READ : (r < 8) ? DDR3CMD_WRITE : CMD_OTHER;
                end else begin
                    i_command_valid = 1'b0;
                end
            end
            if (!i_write_data_valid || wacc) begin
                i_write_data_valid = 1'($urandom_range(0, 1));
                i_write_data       = {$urandom, $urandom};
            end
            i_ch_command_ready    = NCH'($urandom);
            i_ch_write_data_ready = NCH'($urandom);
            i_read_data_ready     = ($urandom_range(0, 3) != 0);
            ch_en                 = NCH'($urandom);
            @(negedge i_clk);
            acc  = i_command_valid && o_command_ready;
            wacc = i_write_data_valid && o_write_data_ready;
            cyc();
        end

        i_command_valid       = 1'b0;
        i_ch_command_ready    = 2'b11;
        i_ch_write_data_ready = 2'b11;
        i_read_data_ready     = 1'b1;
        ch_en                 = 2'b11;
        i_write_data_valid    = 1'b1;
        for (int k = 0; k < 200 && (rseq_m.size() > 0 || wroute_m.size() > 0); k++) cyc();
        i_write_data_valid = 1'b0;
        cyc();
        chk("drain_outstanding", 256'(o_outstanding_reads), 256'(0));
        chk("drain_exp_rd", 256'(exp_rd.size()), 256'(0));
        chk("drain_wdr", 256'(o_write_data_ready), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
